// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon permutation core.
// The state is a packed struct so x0 lands at bits [319:256].
package ascon_pkg;

  typedef logic [63:0] ascon_word_t;

  typedef struct packed {
    ascon_word_t x0;
    ascon_word_t x1;
    ascon_word_t x2;
    ascon_word_t x3;
    ascon_word_t x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } perm_fsm_e;

  localparam logic [3:0] ROUND_MAX = 4'd12;

  localparam logic [5:0] ROT_X0_A = 6'd19;
  localparam logic [5:0] ROT_X0_B = 6'd28;
  localparam logic [5:0] ROT_X1_A = 6'd61;
  localparam logic [5:0] ROT_X1_B = 6'd39;
  localparam logic [5:0] ROT_X2_A = 6'd1;
  localparam logic [5:0] ROT_X2_B = 6'd6;
  localparam logic [5:0] ROT_X3_A = 6'd10;
  localparam logic [5:0] ROT_X3_B = 6'd17;
  localparam logic [5:0] ROT_X4_A = 6'd7;
  localparam logic [5:0] ROT_X4_B = 6'd41;

  // Round constant: high nibble counts down while the low nibble counts up.
  function automatic ascon_word_t ascon_rc(input logic [3:0] idx);
    logic [3:0] hi;
    hi = 4'hF - idx;
    return {56'h0, hi, idx};
  endfunction

  function automatic ascon_word_t rotr64(input ascon_word_t v, input logic [5:0] n);
    logic [127:0] dbl;
    dbl = {v, v} >> n;
    return dbl[63:0];
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round (constant addition, bit-sliced S-box, linear diffusion).
// Purely combinational; chained UNROLL times by the core.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   round_idx,
  output ascon_state_t state_o
);

  ascon_word_t x0, x1, x2, x3, x4;
  ascon_word_t t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i.x0;
    x1 = state_i.x1;
    x2 = state_i.x2 ^ ascon_rc(round_idx);
    x3 = state_i.x3;
    x4 = state_i.x4;

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    // chi: each lane absorbs ~next & next-next, all from pre-chi values
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o.x0 = x0 ^ rotr64(x0, ROT_X0_A) ^ rotr64(x0, ROT_X0_B);
    state_o.x1 = x1 ^ rotr64(x1, ROT_X1_A) ^ rotr64(x1, ROT_X1_B);
    state_o.x2 = x2 ^ rotr64(x2, ROT_X2_A) ^ rotr64(x2, ROT_X2_B);
    state_o.x3 = x3 ^ rotr64(x3, ROT_X3_A) ^ rotr64(x3, ROT_X3_B);
    state_o.x4 = x4 ^ rotr64(x4, ROT_X4_A) ^ rotr64(x4, ROT_X4_B);
  end

endmodule

// File: rtl/ascon_perm_core.sv
// Ascon permutation with 1..12 runtime rounds, UNROLL rounds per clock, valid/ready on both sides.
// ASCON_PERM_ZEROIZE_EN clears the state register when the result is handed off.
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int UNROLL  = 1,
  parameter int STATE_W = 320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [3:0]         num_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_core: UNROLL must be 1 or 2");
  end
  if (STATE_W != 5 * 64) begin : g_bad_state_w
    $error("ascon_perm_core: STATE_W must be 320");
  end

  perm_fsm_e    fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [3:0]   nr_eff;
  ascon_state_t stage1_s, run_state;
  logic [3:0]   run_idx_next;

  assign nr_eff = (num_rounds == 4'd0 || num_rounds > ROUND_MAX) ? ROUND_MAX : num_rounds;

  ascon_round u_round0 (
    .state_i  (state_q),
    .round_idx(round_idx_q),
    .state_o  (stage1_s)
  );

  if (UNROLL == 2) begin : g_unroll2
    ascon_state_t stage2_s;
    logic [3:0]   idx1;
    logic         last_single;

    assign idx1 = round_idx_q + 4'd1;

    ascon_round u_round1 (
      .state_i  (stage1_s),
      .round_idx(idx1),
      .state_o  (stage2_s)
    );

    // Odd round counts finish with a single round; skip the second stage.
    assign last_single  = (round_idx_q == ROUND_MAX - 4'd1);
    assign run_state    = last_single ? stage1_s : stage2_s;
    assign run_idx_next = last_single ? ROUND_MAX : round_idx_q + 4'd2;
  end else begin : g_unroll1
    assign run_state    = stage1_s;
    assign run_idx_next = round_idx_q + 4'd1;
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_idx_d = round_idx_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d     = state_in;
          round_idx_d = ROUND_MAX - nr_eff;
          fsm_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d     = run_state;
        round_idx_d = run_idx_next;
        if (run_idx_next == ROUND_MAX) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    out_valid_d = (fsm_d == ST_DONE);
    busy_d      = (fsm_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_idx_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Directed bench for ascon_perm_core: one UNROLL=1 and one UNROLL=2 instance.
// Expected states come from a table-driven S-box model plus hand-worked single-round words.
module tb_ascon_perm_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid   [2];
  logic         in_ready   [2];
  logic         out_valid  [2];
  logic         out_ready  [2];
  logic         busy       [2];
  logic [319:0] state_in   [2];
  logic [319:0] state_out  [2];
  logic [3:0]   num_rounds [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] sbox_tbl [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  logic [319:0] iv_state = {64'h80400c0600000000, 64'h0001020304050607,
                            64'h08090a0b0c0d0e0f, 64'h1011121314151617,
                            64'h18191a1b1c1d1e1f};

  always #5 clk = ~clk;

  ascon_perm_core #(.UNROLL(1), .STATE_W(320)) dut_u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .num_rounds(num_rounds[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0]), .busy(busy[0])
  );

  ascon_perm_core #(.UNROLL(2), .STATE_W(320)) dut_u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .num_rounds(num_rounds[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1]), .busy(busy[1])
  );

  // Column-wise S-box lookup and bit-indexed rotations.
  function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [63:0] z [5];
    logic [4:0]  col, o;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    x[2] = x[2] ^ 64'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = sbox_tbl[col];
      y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
    end
    for (int i = 0; i < 5; i++)
      for (int b = 0; b < 64; b++)
        z[i][b] = y[i][b] ^ y[i][(b + rot_a[i]) % 64] ^ y[i][(b + rot_b[i]) % 64];
    return {z[0], z[1], z[2], z[3], z[4]};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
    logic [319:0] t;
    t = s;
    for (int r = 12 - nr; r < 12; r++) t = ref_round(t, r);
    return t;
  endfunction

  task automatic run_job(input int u, input logic [319:0] s, input logic [3:0] nr,
                         output int lat, output logic [319:0] res, output int rdy_seen);
    @(negedge clk);
    in_valid[u] = 1'b1; state_in[u] = s; num_rounds[u] = nr;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    lat = 0; rdy_seen = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (in_ready[u] === 1'b1) rdy_seen++;
    end while (out_valid[u] !== 1'b1 && lat < 40);
    res = state_out[u];
  endtask

  task automatic release_job(input int u);
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b0; state_in[u] = '0; num_rounds[u] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (in_ready[u] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready u%0d got %b want 0", u, in_ready[u]); end
      n_cmp++; if (out_valid[u] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid u%0d got %b want 0", u, out_valid[u]); end
      n_cmp++; if (busy[u] !== 1'b0) begin n_err++; $display("FAIL reset_busy u%0d got %b want 0", u, busy[u]); end
      n_cmp++; if (state_out[u] !== 320'h0) begin n_err++; $display("FAIL reset_state u%0d got %h want 0", u, state_out[u]); end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (in_ready[u] !== 1'b1) begin n_err++; $display("FAIL idle_in_ready u%0d got %b want 1", u, in_ready[u]); end
    end
  endtask

  // One round (index 11, constant 0x4b) on the zero state, worked by hand.
  task automatic test_single_round();
    int lat, rdy;
    logic [319:0] res;
    run_job(0, 320'h0, 4'd1, lat, res, rdy);
    release_job(0);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL p1_latency got %0d want 1", lat); end
    n_cmp++; if (res[319:256] !== 64'h000964b00000004b) begin n_err++; $display("FAIL p1_x0 got %h want 000964b00000004b", res[319:256]); end
    n_cmp++; if (res[255:192] !== 64'h0000000096000213) begin n_err++; $display("FAIL p1_x1 got %h want 0000000096000213", res[255:192]); end
    n_cmp++; if (res[191:128] !== 64'h53ffffffffffff90) begin n_err++; $display("FAIL p1_x2 got %h want 53ffffffffffff90", res[191:128]); end
    n_cmp++; if (res[63:0] !== 64'h0) begin n_err++; $display("FAIL p1_x4 got %h want 0", res[63:0]); end
  endtask

  task automatic test_p12_unroll1();
    int lat, rdy;
    logic [319:0] res, exp;
    exp = ref_perm(320'h0, 12);
    run_job(0, 320'h0, 4'd12, lat, res, rdy);
    release_job(0);
    n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL p12_u1_latency got %0d want 12", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL p12_u1_state got %h want %h", res, exp); end
    n_cmp++; if (rdy !== 0) begin n_err++; $display("FAIL p12_u1_in_ready_high_cycles got %0d want 0", rdy); end
  endtask

  task automatic test_iv_unroll2();
    int lat, rdy;
    logic [319:0] res, exp;
    exp = ref_perm(iv_state, 6);
    run_job(1, iv_state, 4'd6, lat, res, rdy);
    release_job(1);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL p6_u2_latency got %0d want 3", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL p6_u2_state got %h want %h", res, exp); end
    exp = ref_perm(iv_state, 8);
    run_job(1, iv_state, 4'd8, lat, res, rdy);
    release_job(1);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL p8_u2_latency got %0d want 4", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL p8_u2_state got %h want %h", res, exp); end
  endtask

  task automatic test_odd_and_clamp();
    int lat, rdy;
    logic [319:0] res, exp;
    exp = ref_perm(iv_state, 7);
    run_job(1, iv_state, 4'd7, lat, res, rdy);
    release_job(1);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL p7_u2_latency got %0d want 4", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL p7_u2_state got %h want %h", res, exp); end
    exp = ref_perm(iv_state, 12);
    run_job(1, iv_state, 4'd0, lat, res, rdy);
    release_job(1);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL nr0_u2_latency got %0d want 6", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL nr0_u2_state got %h want %h", res, exp); end
    run_job(1, iv_state, 4'd15, lat, res, rdy);
    release_job(1);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL nr15_u2_latency got %0d want 6", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL nr15_u2_state got %h want %h", res, exp); end
  endtask

  task automatic test_backpressure();
    int lat, rdy;
    logic [319:0] res, exp;
    exp = ref_perm(iv_state, 8);
    run_job(1, iv_state, 4'd8, lat, res, rdy);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid[1] = (i % 2 == 0); state_in[1] = ~iv_state; num_rounds[1] = 4'd1;
      n_cmp++; if (out_valid[1] !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cyc%0d got %b want 1", i, out_valid[1]); end
      n_cmp++; if (state_out[1] !== exp) begin n_err++; $display("FAIL bp_state cyc%0d got %h want %h", i, state_out[1], exp); end
      n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready[1]); end
    end
    @(negedge clk);
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_handshake_cycle_in_ready got %b want 0", in_ready[1]); end
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL bp_after_in_ready got %b want 1", in_ready[1]); end
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL bp_after_out_valid got %b want 0", out_valid[1]); end
    @(posedge clk); #1;
    n_cmp++; if (busy[1] !== 1'b0) begin n_err++; $display("FAIL bp_no_stray_accept busy got %b want 0", busy[1]); end
  endtask

  task automatic test_reset_mid_run();
    int lat, rdy, ov_seen;
    logic [319:0] res, exp;
    @(negedge clk);
    in_valid[0] = 1'b1; state_in[0] = iv_state; num_rounds[0] = 4'd12;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy[0]); end
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", out_valid[0]); end
    n_cmp++; if (state_out[0] !== 320'h0) begin n_err++; $display("FAIL midrst_state got %h want 0", state_out[0]); end
    @(negedge clk); rst = 1'b0;
    #1;
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready[0]); end
    ov_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid[0] === 1'b1) ov_seen++;
    end
    n_cmp++; if (ov_seen !== 0) begin n_err++; $display("FAIL midrst_out_valid_pulses got %0d want 0", ov_seen); end
    exp = ref_perm(iv_state, 12);
    run_job(0, iv_state, 4'd12, lat, res, rdy);
    release_job(0);
    n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL midrst_next_latency got %0d want 12", lat); end
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL midrst_next_state got %h want %h", res, exp); end
  endtask

  task automatic test_zeroize();
    int lat, rdy;
    logic [319:0] res, exp_idle;
    run_job(0, iv_state, 4'd6, lat, res, rdy);
    n_cmp++; if (res !== ref_perm(iv_state, 6)) begin n_err++; $display("FAIL zero_job_state got %h want %h", res, ref_perm(iv_state, 6)); end
`ifdef ASCON_PERM_ZEROIZE_EN
    exp_idle = 320'h0;
`else
    exp_idle = res;
`endif
    release_job(0);
    n_cmp++; if (state_out[0] !== exp_idle) begin n_err++; $display("FAIL idle_state got %h want %h", state_out[0], exp_idle); end
    @(posedge clk); #1;
    n_cmp++; if (state_out[0] !== exp_idle) begin n_err++; $display("FAIL idle_state_hold got %h want %h", state_out[0], exp_idle); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_round();
    test_p12_unroll1();
    test_iv_unroll2();
    test_odd_and_clamp();
    test_backpressure();
    test_reset_mid_run();
    test_zeroize();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_perm_core.md
Name: ascon_perm_core

Overview:
Parametrised Ascon permutation engine. It applies a runtime-selectable number of rounds (p12/p8/p6, or any count from 1 to 12) to a 320-bit state, with UNROLL rounds per clock. Valid/ready handshakes sit on input and output so the engine can be placed directly between the AEAD/hash controller and its state register. It replaces the fixed 12-round, level-start permutation with a generalised core.

Parameters:
UNROLL, 1, rounds computed per clock cycle; legal values 1 or 2; any other value fails elaboration.
STATE_W, 320, state width; fixed by Ascon; checked equal to 5*64 at elaboration.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  state_in/num_rounds valid
in_ready  output  1  core idle and able to accept a job
state_in  input  320  input state, {x0,x1,x2,x3,x4}, x0 at [319:256]
num_rounds  input  4  rounds to apply; 1..12 legal; 0 or >12 treated as 12
out_valid  output  1  state_out holds the finished result
out_ready  input  1  consumer accepts the result
state_out  output  320  permuted state, same word order as state_in
busy  output  1  high in RUN and DONE

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset forces IDLE, state register 0, round_idx 0, out_valid 0, busy 0.
- in_ready = (fsm==IDLE) && !rst. out_valid = (fsm==DONE). state_out drives the state register directly, with no extra flop.
- IDLE: when in_valid && in_ready, latch state_in and set round_idx = 12 - nr_eff, where nr_eff = (num_rounds==0 || num_rounds>12) ? 12 : num_rounds. Then go to RUN.
- RUN: each cycle apply k = min(UNROLL, 12 - round_idx) rounds, using indices round_idx, round_idx+1, ...; then round_idx += k. When round_idx reaches 12, go to DONE.
- With UNROLL=2 and an odd nr_eff, the last RUN cycle applies one round. The second stage is bypassed by a mux.
- Round i:
  - p_C: x2 ^= {56'h0, (4'hF - i), i[3:0]}.
  - p_S: 5-bit Ascon S-box, bit-sliced: x0^=x4, x4^=x3, x2^=x1, chi, x1^=x0, x0^=x4, x3^=x2, x2=~x2.
  - p_L: right rotations (19,28), (61,39), (1,6), (10,17), (7,41) on x0..x4 respectively.
- Latency: accept edge k; RUN spans ceil(nr_eff/UNROLL) cycles; out_valid is high after edge k+ceil(nr_eff/UNROLL).
- DONE: state_out is held stable while out_valid && !out_ready. On out_ready, go to IDLE. A new job cannot be accepted in that same cycle: in_ready rises the next cycle.
- in_valid while not IDLE is ignored. The upstream must hold in_valid and data until in_ready.
- Reset mid-RUN or mid-DONE: the job is aborted and no out_valid pulse occurs; the next cycle is IDLE.
- All state updates use nonblocking assignments. Round logic is purely combinational between registers.

Optional Feature:
ASCON_PERM_ZEROIZE_EN.
- Defined: on the DONE→IDLE handshake the state register is cleared to 0, so state_out reads 0 in IDLE. Input state is only visible during RUN/DONE.
- Undefined: the state register keeps its last result in IDLE, and state_out shows it.

Decomposition:
- Package ascon_pkg:
  - typedef ascon_word_t (logic [63:0]) and ascon_state_t (5 words).
  - ROUND_MAX=12.
  - Function ascon_rc(idx).
  - Function rotr64.
  - Localparams for the ten rotation offsets.
- Sub-module ascon_round: combinational, inputs ascon_state_t and 4-bit round index, output ascon_state_t. It is instantiated UNROLL times in a chain.

Test Plan:
- UNROLL=1, num_rounds=12, state_in=0 → out_valid exactly 12 cycles after accept; state_out bit-exact to the C reference model p12(0); in_ready low throughout.
- UNROLL=2, num_rounds=6 then 8, on the Ascon-128 IV state 0x80400c0600000000‖key‖nonce (key=000102…0F, nonce=101112…1F) → latencies 3 and 4 cycles; results match the model's p6/p8.
- UNROLL=2, num_rounds=7 → 4 RUN cycles, round indices 5..11 applied once each, result equals model p7; num_rounds=0 and 15 both behave as 12.
- Back-pressure: hold out_ready=0 for 20 cycles → state_out stable and out_valid high; in_valid pulses during that time are not accepted; after out_ready, in_ready rises one cycle later.
- rst asserted at the 5th RUN cycle → next cycle IDLE, out_valid never pulses, a subsequent job produces a correct result.
- ASCON_PERM_ZEROIZE_EN defined → state_out==0 the cycle after output handshake; undefined → state_out retains the result.
